// File: rtl/statelogic.sv
// statelogic: multicycle MIPS controller state sequencer with illegal-op and retire pulses
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   op      : opcode from IR[31:26]
//   memrdy  : memory handshake, gates FETCH1-4, LBRD, SBWR
//   state   : registered controller state for outputlogic
//   illegal : one-cycle pulse on an unsupported opcode
//   done    : one-cycle pulse in the first FETCH1 after retirement
//   Define STATELOGIC_ADDI_EN to add the ADDIEX/ADDIWR path.
module statelogic (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memrdy,
  output logic [3:0] state,
  output logic       illegal,
  output logic       done
);
  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;
  localparam logic [5:0] LB    = 6'b100000;
  localparam logic [5:0] SB    = 6'b101000;
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] J     = 6'b000010;
`ifdef STATELOGIC_ADDI_EN
  localparam logic [5:0] ADDI  = 6'b001000;
`endif
  state_t st;
  assign state = st;
  // pulses default low and are set only on the edge that enters FETCH1
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st      <= FETCH1;
      illegal <= 1'b0;
      done    <= 1'b0;
    end else begin
      illegal <= 1'b0;
      done    <= 1'b0;
      case (st)
        FETCH1: st <= memrdy ? FETCH2 : FETCH1;
        FETCH2: st <= memrdy ? FETCH3 : FETCH2;
        FETCH3: st <= memrdy ? FETCH4 : FETCH3;
        FETCH4: st <= memrdy ? DECODE : FETCH4;
        DECODE:
          case (op)
            LB, SB: st <= MEMADR;
            RTYPE:  st <= RTYPEEX;
            BEQ:    st <= BEQEX;
            J:      st <= JEX;
`ifdef STATELOGIC_ADDI_EN
            ADDI:   st <= ADDIEX;
`endif
            default: begin
              st      <= FETCH1;
              illegal <= 1'b1;
            end
          endcase
        // op changing between DECODE and MEMADR is a protocol violation
        MEMADR: begin
          st      <= op == LB ? LBRD : op == SB ? SBWR : FETCH1;
          illegal <= op != LB && op != SB;
        end
        LBRD: st <= memrdy ? LBWR : LBRD;
        LBWR: begin
          st   <= FETCH1;
          done <= 1'b1;
        end
        SBWR: begin
          st   <= memrdy ? FETCH1 : SBWR;
          done <= memrdy;
        end
        RTYPEEX: st <= RTYPEWR;
        RTYPEWR, BEQEX, JEX: begin
          st   <= FETCH1;
          done <= 1'b1;
        end
`ifdef STATELOGIC_ADDI_EN
        ADDIEX: st <= ADDIWR;
        ADDIWR: begin
          st   <= FETCH1;
          done <= 1'b1;
        end
`endif
        default: st <= FETCH1;
      endcase
    end
endmodule

// File: tb/tb_statelogic.sv
// tb_statelogic: directed scoreboard bench for statelogic
module tb_statelogic;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       memrdy;
  logic [3:0] state;
  logic       illegal;
  logic       done;
  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];
  localparam logic [5:0] LB    = 6'b100000;
  localparam logic [5:0] SB    = 6'b101000;
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] ADDI  = 6'b001000;
  statelogic dut (
    .clk(clk),
    .reset(reset),
    .op(op),
    .memrdy(memrdy),
    .state(state),
    .illegal(illegal),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [5:0] e);
    checks++;
    assert ({state, illegal, done} === e) else begin
      failures++;
      $error("FAIL %s: state/illegal/done observed=%0d/%0b/%0b expected=%0d/%0b/%0b",
             tag, state, illegal, done, e[5:2], e[1], e[0]);
    end
  endtask
  // push expectation, clock once, pop and compare 1 time unit after the edge
  task automatic cyc(input string tag, input logic mr, input logic [3:0] s,
                     input logic il, input logic dn);
    logic [5:0] e;
    memrdy = mr;
    exp_q.push_back({s, il, dn});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, e);
  endtask
  task automatic fetch(input string tag);
    for (int i = 1; i <= 4; i++) cyc(tag, 1'b1, 4'(i), 1'b0, 1'b0);
  endtask
  initial begin
    reset = 1'b0;
    memrdy = 1'b0;
    op = LB;
    #12;
    chk("reset_values", 6'd0);
    @(negedge clk);
    reset = 1'b1;
    // LB full path
    fetch("lb_fetch");
    for (int i = 5; i <= 7; i++) cyc("lb_body", 1'b1, 4'(i), 1'b0, 1'b0);
    cyc("lb_retire", 1'b1, 4'd0, 1'b0, 1'b1);
    // reset mid-LBRD
    fetch("rst_fetch");
    cyc("rst_memadr", 1'b1, 4'd5, 1'b0, 1'b0);
    cyc("rst_lbrd", 1'b1, 4'd6, 1'b0, 1'b0);
    cyc("rst_lbrd_hold", 1'b0, 4'd6, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 chk("rst_async", 6'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc("rst_release", 1'b1, 4'd1, 1'b0, 1'b0);
    cyc("rst_no_retire_a", 1'b1, 4'd2, 1'b0, 1'b0);
    cyc("rst_no_retire_b", 1'b1, 4'd3, 1'b0, 1'b0);
    cyc("rst_decode", 1'b1, 4'd4, 1'b0, 1'b0);
    op = BEQ;
    cyc("rst_beq", 1'b1, 4'd11, 1'b0, 1'b0);
    cyc("rst_beq_retire", 1'b1, 4'd0, 1'b0, 1'b1);
    // SB with memrdy stalls in FETCH2 and SBWR
    op = SB;
    cyc("sb_f1", 1'b1, 4'd1, 1'b0, 1'b0);
    cyc("sb_stall_f2a", 1'b0, 4'd1, 1'b0, 1'b0);
    cyc("sb_stall_f2b", 1'b0, 4'd1, 1'b0, 1'b0);
    cyc("sb_f3", 1'b1, 4'd2, 1'b0, 1'b0);
    cyc("sb_f4", 1'b1, 4'd3, 1'b0, 1'b0);
    cyc("sb_dec", 1'b1, 4'd4, 1'b0, 1'b0);
    cyc("sb_memadr", 1'b1, 4'd5, 1'b0, 1'b0);
    cyc("sb_sbwr", 1'b1, 4'd8, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("sb_stall_wr", 1'b0, 4'd8, 1'b0, 1'b0);
    cyc("sb_retire", 1'b1, 4'd0, 1'b0, 1'b1);
    // RTYPE, BEQ, J back-to-back; memrdy low outside memory states is ignored
    op = RTYPE;
    fetch("rt_fetch");
    cyc("rt_ex", 1'b0, 4'd9, 1'b0, 1'b0);
    cyc("rt_wr", 1'b0, 4'd10, 1'b0, 1'b0);
    cyc("rt_retire", 1'b0, 4'd0, 1'b0, 1'b1);
    op = BEQ;
    fetch("beq_fetch");
    cyc("beq_ex", 1'b0, 4'd11, 1'b0, 1'b0);
    cyc("beq_retire", 1'b1, 4'd0, 1'b0, 1'b1);
    op = J;
    fetch("j_fetch");
    cyc("j_ex", 1'b1, 4'd12, 1'b0, 1'b0);
    cyc("j_retire", 1'b1, 4'd0, 1'b0, 1'b1);
    // illegal opcode
    op = 6'b111111;
    fetch("ill_fetch");
    cyc("ill_return", 1'b1, 4'd0, 1'b1, 1'b0);
    cyc("ill_pulse_end", 1'b1, 4'd1, 1'b0, 1'b0);
    for (int i = 2; i <= 4; i++) cyc("ill2_fetch", 1'b1, 4'(i), 1'b0, 1'b0);
    cyc("ill2_return", 1'b1, 4'd0, 1'b1, 1'b0);
    // op changes between DECODE and MEMADR
    op = LB;
    fetch("viol_fetch");
    cyc("viol_memadr", 1'b1, 4'd5, 1'b0, 1'b0);
    op = RTYPE;
    cyc("viol_return", 1'b1, 4'd0, 1'b1, 1'b0);
    // ADDI depends on configuration
    op = ADDI;
    fetch("addi_fetch");
`ifdef STATELOGIC_ADDI_EN
    cyc("addi_ex", 1'b1, 4'd13, 1'b0, 1'b0);
    cyc("addi_wr", 1'b1, 4'd14, 1'b0, 1'b0);
    cyc("addi_retire", 1'b1, 4'd0, 1'b0, 1'b1);
`else
    cyc("addi_illegal", 1'b1, 4'd0, 1'b1, 1'b0);
`endif
    cyc("final", 1'b1, 4'd1, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/statelogic.md
# statelogic

Multicycle control sequencer for the 8-bit MIPS datapath. It holds the 4-bit controller state register and advances it from the instruction opcode and a memory-ready handshake. Its `state` output is the input consumed by `outputlogic`, which decodes it into datapath control signals. It also flags illegal opcodes and pulses once per retired instruction.

## Interface
- No parameters; state encodings are fixed localparams, listed below.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: reset, asynchronous, active-low; clears all registers immediately.
- `op` input, 6 bits: opcode from the instruction register (`IR[31:26]`); stable from DECODE until the instruction completes.
- `memrdy` input, 1 bit: memory handshake; gates advance out of memory-access states.
- `state` output, 4 bits: current controller state (registered).
- `illegal` output, 1 bit: one-cycle pulse (registered) on an unsupported opcode.
- `done` output, 1 bit: one-cycle pulse (registered) on instruction retirement.

## Operation
- State encodings: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14.
- Opcodes: LB=6'b100000, SB=6'b101000, RTYPE=6'b000000, BEQ=6'b000100, J=6'b000010, ADDI=6'b001000.
- Memory states are FETCH1–FETCH4, LBRD and SBWR. In these states the FSM advances only when `memrdy`=1; otherwise it holds state.
- Fetch path: FETCH1→FETCH2→FETCH3→FETCH4→DECODE.
- DECODE branches on `op`:
  - LB or SB → MEMADR
  - RTYPE → RTYPEEX
  - BEQ → BEQEX
  - J → JEX
  - ADDI → ADDIEX (only when configured)
  - any other opcode → FETCH1, with `illegal` pulsed.
- MEMADR: LB → LBRD; SB → SBWR. Any other `op` (a protocol violation) → FETCH1 with `illegal` pulsed.
- Remaining transitions:
  - LBRD→LBWR (gated by `memrdy`), then LBWR→FETCH1.
  - SBWR→FETCH1 (gated by `memrdy`).
  - RTYPEEX→RTYPEWR→FETCH1.
  - BEQEX→FETCH1; JEX→FETCH1.
  - ADDIEX→ADDIWR→FETCH1.
- Retirement: `done`=1 for exactly the first cycle in FETCH1 after leaving LBWR, SBWR, RTYPEWR, BEQEX, JEX or ADDIWR. `done` is never asserted on an illegal return.
- Unused encodings (15, and 13/14 when ADDI is compiled out) → FETCH1 on the next edge. Neither `done` nor `illegal` is asserted.
- `illegal` and `done` are mutually exclusive in every cycle.

## Timing
- Reset values: `state`=0 (FETCH1), `illegal`=0, `done`=0. Reset is asserted asynchronously and released synchronously; the first transition happens at the first rising edge after `reset` goes high.
- One state transition per clock. `state`, `illegal` and `done` all update on the same edge.
- Latency from FETCH1 back to FETCH1, with `memrdy` held at 1:
  - LB: 8 cycles
  - SB, RTYPE, ADDI: 7 cycles
  - BEQ, J: 6 cycles
  - illegal opcode: 5 cycles
- Each cycle with `memrdy`=0 in a memory state adds exactly one cycle.
- `memrdy` is ignored in non-memory states.
- Reset mid-instruction: `state` returns to 0 immediately and both pulses clear. No partial retirement is signalled.

## Configuration
- `STATELOGIC_ADDI_EN` defined: ADDIEX and ADDIWR exist; ADDI retires in 7 cycles with a `done` pulse.
- `STATELOGIC_ADDI_EN` undefined: ADDI is treated as illegal (DECODE→FETCH1, `illegal` pulses). Encodings 13 and 14 are unused and recover to FETCH1.

## Test plan
- Reset low mid-LBRD, then release → `state`=0 immediately; `illegal`=`done`=0; the next edge with `memrdy`=1 gives `state`=1.
- `op`=LB, `memrdy`=1 → `state` sequence 0,1,2,3,4,5,6,7,0; `done`=1 only in the cycle `state` returns to 0.
- `op`=SB, `memrdy` held low for 2 cycles in FETCH2 and 3 cycles in SBWR → sequence 0,1,1,1,2,3,4,5,8,8,8,8,0; total 12 cycles; one `done` pulse.
- `op`=RTYPE, then BEQ, then J back-to-back → 0–4,9,10,0–4,11,0–4,12,0; three `done` pulses; `illegal` stays 0.
- `op`=6'b111111 → 0,1,2,3,4,0; `illegal`=1 for one cycle; `done` stays 0.
- `op`=ADDI → with the macro: 0–4,13,14,0 and `done`. Without the macro: 0–4,0 and `illegal`.
